// File: rtl/turn_scheduler.sv
// Turn sequencer for the 3x3 game: button arbitration, cursor, place handshake, board clear.
// Define TURN_TIMER_EN to build the per-turn countdown and forfeit; otherwise sec_left reads 0.
module turn_scheduler #(
  parameter int TICKS_PER_SEC = 8,
  parameter int TURN_SECONDS  = 9,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       tick,
  input  logic [6:0] btn,
  input  logic       place_ack,
  input  logic       place_nack,
  input  logic       game_over,
  output logic [3:0] cursor,
  output logic       turn,
  output logic       place_req,
  output logic [3:0] place_cell,
  output logic       place_player,
  output logic       board_clear,
  output logic [3:0] sec_left,
  output logic       ack_err
);

  localparam int B_BLUE  = 6;
  localparam int B_RED   = 5;
  localparam int B_DEC   = 4;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_PLAY, S_REQ, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cursor_q, cursor_d;
  logic              turn_q, turn_d;
  logic              place_req_q, place_req_d;
  logic [3:0]        place_cell_q, place_cell_d;
  logic              place_player_q, place_player_d;
  logic              board_clear_q, board_clear_d;
  logic              ack_err_q, ack_err_d;
  logic              blue_want_q, blue_want_d;
  logic              red_want_q, red_want_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [6:0]        btn_q, press, sel;
  logic [1:0]        row, col, row_n, col_n;
  logic [3:0]        nav_cursor;
  logic              clear_go, turn_now;

`ifdef TURN_TIMER_EN
  localparam int                TICK_W    = $clog2(TICKS_PER_SEC + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [3:0]        RELOAD    = 4'(TURN_SECONDS);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        sec_left_q, sec_left_d;
`else
  logic unused_timer;
  assign unused_timer = tick ^ (TICKS_PER_SEC > 0) ^ (TURN_SECONDS > 0);
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    cursor_d       = cursor_q;
    turn_d         = turn_q;
    place_req_d    = place_req_q;
    place_cell_d   = place_cell_q;
    place_player_d = place_player_q;
    board_clear_d  = 1'b0;
    ack_err_d      = 1'b0;
    blue_want_d    = blue_want_q;
    red_want_d     = red_want_q;
    wait_cnt_d     = wait_cnt_q;
`ifdef TURN_TIMER_EN
    tick_cnt_d     = tick_cnt_q;
    sec_left_d     = sec_left_q;
`endif
    turn_now       = turn_q;

    // Only the highest-priority new press survives; the rest are dropped.
    press = btn & ~btn_q;
    sel   = '0;
    for (int i = 0; i < 7; i++) begin
      if (press[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end

    case (cursor_q)
      4'd0, 4'd1, 4'd2: row = 2'd0;
      4'd3, 4'd4, 4'd5: row = 2'd1;
      default:          row = 2'd2;
    endcase
    case (cursor_q)
      4'd0, 4'd3, 4'd6: col = 2'd0;
      4'd1, 4'd4, 4'd7: col = 2'd1;
      default:          col = 2'd2;
    endcase

    row_n = row;
    col_n = col;
    if (sel[B_UP])    row_n = (row == 2'd0) ? 2'd2 : row - 2'd1;
    if (sel[B_DOWN])  row_n = (row == 2'd2) ? 2'd0 : row + 2'd1;
    if (sel[B_LEFT])  col_n = (col == 2'd0) ? 2'd2 : col - 2'd1;
    if (sel[B_RIGHT]) col_n = (col == 2'd2) ? 2'd0 : col + 2'd1;
    nav_cursor = 4'({row_n, 1'b0}) + 4'(row_n) + 4'(col_n);

    if (sel[B_BLUE]) blue_want_d = 1'b1;
    if (sel[B_RED])  red_want_d  = 1'b1;
    clear_go = (state_q != S_CLEAR) &&
               ((blue_want_q && red_want_q) || (game_over && (blue_want_q || red_want_q)));

    if (state_q == S_CLEAR) begin
      state_d     = S_PLAY;
      turn_d      = 1'b0;
      cursor_d    = 4'd4;
      blue_want_d = 1'b0;
      red_want_d  = 1'b0;
`ifdef TURN_TIMER_EN
      sec_left_d  = RELOAD;
      tick_cnt_d  = '0;
`endif
    end else if (clear_go) begin
      state_d       = S_CLEAR;
      board_clear_d = 1'b1;
      place_req_d   = 1'b0;
    end else if (state_q == S_REQ) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      // A nack wins over a simultaneous ack: the board did not take the mark.
      if (place_nack) begin
        place_req_d = 1'b0;
        state_d     = S_PLAY;
      end else if (place_ack) begin
        place_req_d = 1'b0;
        turn_d      = ~turn_q;
        state_d     = S_PLAY;
`ifdef TURN_TIMER_EN
        sec_left_d  = RELOAD;
        tick_cnt_d  = '0;
`endif
      end else if (wait_cnt_q == WAIT_LAST) begin
        place_req_d = 1'b0;
        ack_err_d   = 1'b1;
        state_d     = S_PLAY;
      end
    end else begin
`ifdef TURN_TIMER_EN
      if (!game_over && tick) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          if (sec_left_q != 4'd0) begin
            sec_left_d = sec_left_q - 4'd1;
          end else begin
            turn_now   = ~turn_q;
            sec_left_d = RELOAD;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
`endif
      turn_d = turn_now;
      // A decision in the forfeit cycle places for the player who now holds the turn.
      if (!game_over) begin
        if (sel[B_DEC]) begin
          state_d        = S_REQ;
          place_cell_d   = cursor_q;
          place_player_d = turn_now;
          place_req_d    = 1'b1;
          wait_cnt_d     = '0;
        end else if (|sel[B_UP:B_RIGHT]) begin
          cursor_d = nav_cursor;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_button) begin
      state_q        <= S_PLAY;
      cursor_q       <= 4'd4;
      turn_q         <= 1'b0;
      place_req_q    <= 1'b0;
      place_cell_q   <= 4'd0;
      place_player_q <= 1'b0;
      board_clear_q  <= 1'b0;
      ack_err_q      <= 1'b0;
      blue_want_q    <= 1'b0;
      red_want_q     <= 1'b0;
      wait_cnt_q     <= '0;
      btn_q          <= 7'h7F;
`ifdef TURN_TIMER_EN
      tick_cnt_q     <= '0;
      sec_left_q     <= RELOAD;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      turn_q         <= turn_d;
      place_req_q    <= place_req_d;
      place_cell_q   <= place_cell_d;
      place_player_q <= place_player_d;
      board_clear_q  <= board_clear_d;
      ack_err_q      <= ack_err_d;
      blue_want_q    <= blue_want_d;
      red_want_q     <= red_want_d;
      wait_cnt_q     <= wait_cnt_d;
      btn_q          <= btn;
`ifdef TURN_TIMER_EN
      tick_cnt_q     <= tick_cnt_d;
      sec_left_q     <= sec_left_d;
`endif
    end
  end

  assign cursor       = cursor_q;
  assign turn         = turn_q;
  assign place_req    = place_req_q;
  assign place_cell   = place_cell_q;
  assign place_player = place_player_q;
  assign board_clear  = board_clear_q;
  assign ack_err      = ack_err_q;
`ifdef TURN_TIMER_EN
  assign sec_left     = sec_left_q;
`else
  assign sec_left     = 4'd0;
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler; expectations are hand-derived for the default parameters.
module tb_turn_scheduler;

  localparam logic [6:0] BLUE  = 7'b1000000;
  localparam logic [6:0] RED   = 7'b0100000;
  localparam logic [6:0] DEC   = 7'b0010000;
  localparam logic [6:0] UP    = 7'b0001000;
  localparam logic [6:0] DOWN  = 7'b0000100;
  localparam logic [6:0] LEFT  = 7'b0000010;
  localparam logic [6:0] RIGHT = 7'b0000001;

`ifdef TURN_TIMER_EN
  localparam logic [3:0] SEC_FULL = 4'd9;
  localparam bit         TIMER_ON = 1'b1;
`else
  localparam logic [3:0] SEC_FULL = 4'd0;
  localparam bit         TIMER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_button;
  logic       tick;
  logic [6:0] btn;
  logic       place_ack;
  logic       place_nack;
  logic       game_over;
  logic [3:0] cursor;
  logic       turn;
  logic       place_req;
  logic [3:0] place_cell;
  logic       place_player;
  logic       board_clear;
  logic [3:0] sec_left;
  logic       ack_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  turn_scheduler dut (
    .clk          (clk),
    .reset_button (reset_button),
    .tick         (tick),
    .btn          (btn),
    .place_ack    (place_ack),
    .place_nack   (place_nack),
    .game_over    (game_over),
    .cursor       (cursor),
    .turn         (turn),
    .place_req    (place_req),
    .place_cell   (place_cell),
    .place_player (place_player),
    .board_clear  (board_clear),
    .sec_left     (sec_left),
    .ack_err      (ack_err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One press: high for one edge, released for the next so the edge detector re-arms.
  task automatic press(input logic [6:0] b);
    btn = b;
    cycle(1);
    btn = 7'h00;
    cycle(1);
  endtask

  task automatic test_reset;
    reset_button = 1'b1;
    btn          = RIGHT;
    cycle(2);
    n_checks++; if (cursor !== 4'd4) $display("FAIL reset_cursor: got %0d want 4", cursor); else n_pass++;
    n_checks++; if (turn !== 1'b0) $display("FAIL reset_turn: got %0b want 0", turn); else n_pass++;
    n_checks++; if (place_req !== 1'b0) $display("FAIL reset_place_req: got %0b want 0", place_req); else n_pass++;
    n_checks++; if (place_cell !== 4'd0) $display("FAIL reset_place_cell: got %0d want 0", place_cell); else n_pass++;
    n_checks++; if (place_player !== 1'b0) $display("FAIL reset_place_player: got %0b want 0", place_player); else n_pass++;
    n_checks++; if (board_clear !== 1'b0) $display("FAIL reset_board_clear: got %0b want 0", board_clear); else n_pass++;
    n_checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %0b want 0", ack_err); else n_pass++;
    n_checks++; if (sec_left !== SEC_FULL) $display("FAIL reset_sec_left: got %0d want %0d", sec_left, SEC_FULL); else n_pass++;
    reset_button = 1'b0;
    cycle(1);
    n_checks++; if (cursor !== 4'd4) $display("FAIL held_button_through_reset: got %0d want 4", cursor); else n_pass++;
    btn = 7'h00;
    cycle(1);
  endtask

  task automatic test_cursor;
    press(RIGHT);
    n_checks++; if (cursor !== 4'd5) $display("FAIL cursor_right_4_to_5: got %0d want 5", cursor); else n_pass++;
    press(RIGHT);
    n_checks++; if (cursor !== 4'd3) $display("FAIL cursor_right_wrap_5_to_3: got %0d want 3", cursor); else n_pass++;
    press(DOWN);
    n_checks++; if (cursor !== 4'd6) $display("FAIL cursor_down_3_to_6: got %0d want 6", cursor); else n_pass++;
    n_checks++; if (turn !== 1'b0) $display("FAIL cursor_turn_unchanged: got %0b want 0", turn); else n_pass++;
    press(LEFT);
    n_checks++; if (cursor !== 4'd8) $display("FAIL cursor_left_wrap_6_to_8: got %0d want 8", cursor); else n_pass++;
    press(DOWN);
    n_checks++; if (cursor !== 4'd2) $display("FAIL cursor_down_wrap_8_to_2: got %0d want 2", cursor); else n_pass++;
    press(UP);
    n_checks++; if (cursor !== 4'd8) $display("FAIL cursor_up_wrap_2_to_8: got %0d want 8", cursor); else n_pass++;
    press(LEFT);
    press(LEFT);
    n_checks++; if (cursor !== 4'd6) $display("FAIL cursor_left_8_to_6: got %0d want 6", cursor); else n_pass++;
  endtask

  task automatic test_ack;
    int high_cnt;
    btn = DEC;
    cycle(1);
    btn = 7'h00;
    n_checks++; if (place_req !== 1'b1) $display("FAIL ack_req_raised: got %0b want 1", place_req); else n_pass++;
    n_checks++; if (place_cell !== 4'd6) $display("FAIL ack_place_cell: got %0d want 6", place_cell); else n_pass++;
    n_checks++; if (place_player !== 1'b0) $display("FAIL ack_place_player: got %0b want 0", place_player); else n_pass++;
    high_cnt = 1;
    repeat (2) begin
      cycle(1);
      if (place_req === 1'b1) high_cnt++;
    end
    n_checks++; if (place_cell !== 4'd6) $display("FAIL ack_place_cell_held: got %0d want 6", place_cell); else n_pass++;
    place_ack = 1'b1;
    cycle(1);
    place_ack = 1'b0;
    n_checks++; if (place_req !== 1'b0) $display("FAIL ack_req_dropped: got %0b want 0", place_req); else n_pass++;
    n_checks++; if (high_cnt != 3) $display("FAIL ack_req_high_cycles: got %0d want 3", high_cnt); else n_pass++;
    n_checks++; if (turn !== 1'b1) $display("FAIL ack_turn_toggled: got %0b want 1", turn); else n_pass++;
    n_checks++; if (sec_left !== SEC_FULL) $display("FAIL ack_sec_left: got %0d want %0d", sec_left, SEC_FULL); else n_pass++;
  endtask

  task automatic test_nack;
    btn = DEC;
    cycle(1);
    btn = 7'h00;
    n_checks++; if (place_player !== 1'b1) $display("FAIL nack_place_player: got %0b want 1", place_player); else n_pass++;
    press(RIGHT);
    n_checks++; if (cursor !== 4'd6) $display("FAIL nack_nav_ignored_in_req: got %0d want 6", cursor); else n_pass++;
    n_checks++; if (place_req !== 1'b1) $display("FAIL nack_req_still_high: got %0b want 1", place_req); else n_pass++;
    place_ack  = 1'b1;
    place_nack = 1'b1;
    cycle(1);
    place_ack  = 1'b0;
    place_nack = 1'b0;
    n_checks++; if (place_req !== 1'b0) $display("FAIL nack_req_dropped: got %0b want 0", place_req); else n_pass++;
    n_checks++; if (turn !== 1'b1) $display("FAIL nack_turn_unchanged: got %0b want 1", turn); else n_pass++;
    n_checks++; if (ack_err !== 1'b0) $display("FAIL nack_no_ack_err: got %0b want 0", ack_err); else n_pass++;
  endtask

  task automatic test_timeout;
    int high_cnt;
    btn = DEC;
    cycle(1);
    btn = 7'h00;
    high_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      cycle(1);
      if (place_req !== 1'b1) break;
      high_cnt++;
    end
    n_checks++; if (high_cnt != 15) $display("FAIL timeout_req_high_cycles: got %0d want 15", high_cnt); else n_pass++;
    n_checks++; if (ack_err !== 1'b1) $display("FAIL timeout_ack_err_pulse: got %0b want 1", ack_err); else n_pass++;
    cycle(1);
    n_checks++; if (ack_err !== 1'b0) $display("FAIL timeout_ack_err_one_cycle: got %0b want 0", ack_err); else n_pass++;
    n_checks++; if (turn !== 1'b1) $display("FAIL timeout_turn_unchanged: got %0b want 1", turn); else n_pass++;
    press(RIGHT);
    n_checks++; if (cursor !== 4'd7) $display("FAIL timeout_back_in_play: got %0d want 7", cursor); else n_pass++;
  endtask

  task automatic test_arbitration;
    press(UP | RIGHT);
    n_checks++; if (cursor !== 4'd4) $display("FAIL arb_up_beats_right: got %0d want 4", cursor); else n_pass++;
    press(RIGHT);
    press(BLUE | DEC);
    n_checks++; if (place_req !== 1'b0) $display("FAIL arb_blue_beats_decision: got %0b want 0", place_req); else n_pass++;
  endtask

  task automatic test_restart;
    int clear_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      if (board_clear === 1'b1) clear_seen++;
    end
    n_checks++; if (clear_seen != 0) $display("FAIL restart_single_want_no_clear: got %0d pulses want 0", clear_seen); else n_pass++;
    press(RED);
    n_checks++; if (board_clear !== 1'b1) $display("FAIL restart_board_clear_pulse: got %0b want 1", board_clear); else n_pass++;
    cycle(1);
    n_checks++; if (board_clear !== 1'b0) $display("FAIL restart_board_clear_one_cycle: got %0b want 0", board_clear); else n_pass++;
    n_checks++; if (turn !== 1'b0) $display("FAIL restart_turn: got %0b want 0", turn); else n_pass++;
    n_checks++; if (cursor !== 4'd4) $display("FAIL restart_cursor: got %0d want 4", cursor); else n_pass++;
    n_checks++; if (sec_left !== SEC_FULL) $display("FAIL restart_sec_left: got %0d want %0d", sec_left, SEC_FULL); else n_pass++;
  endtask

  task automatic test_game_over_restart;
    game_over = 1'b1;
    press(RIGHT);
    n_checks++; if (cursor !== 4'd4) $display("FAIL game_over_nav_ignored: got %0d want 4", cursor); else n_pass++;
    press(BLUE);
    n_checks++; if (board_clear !== 1'b1) $display("FAIL game_over_single_want_clear: got %0b want 1", board_clear); else n_pass++;
    cycle(1);
    n_checks++; if (board_clear !== 1'b0) $display("FAIL game_over_clear_one_cycle: got %0b want 0", board_clear); else n_pass++;
    game_over = 1'b0;
    cycle(1);
  endtask

  task automatic test_countdown;
    logic [3:0] exp_sec;
    logic       exp_turn;
    tick = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      cycle(1);
      if (k == 7) begin
        exp_sec = SEC_FULL;
        n_checks++; if (sec_left !== exp_sec) $display("FAIL countdown_k7: got %0d want %0d", sec_left, exp_sec); else n_pass++;
      end
      if (k == 8) begin
        exp_sec = TIMER_ON ? 4'd8 : 4'd0;
        n_checks++; if (sec_left !== exp_sec) $display("FAIL countdown_k8: got %0d want %0d", sec_left, exp_sec); else n_pass++;
      end
      if (k == 72) begin
        n_checks++; if (sec_left !== 4'd0) $display("FAIL countdown_k72: got %0d want 0", sec_left); else n_pass++;
      end
      if (k == 79) begin
        n_checks++; if (turn !== 1'b0) $display("FAIL countdown_k79_turn: got %0b want 0", turn); else n_pass++;
      end
      if (k == 80) begin
        exp_turn = TIMER_ON ? 1'b1 : 1'b0;
        exp_sec  = SEC_FULL;
        n_checks++; if (turn !== exp_turn) $display("FAIL forfeit_turn: got %0b want %0b", turn, exp_turn); else n_pass++;
        n_checks++; if (sec_left !== exp_sec) $display("FAIL forfeit_sec_reload: got %0d want %0d", sec_left, exp_sec); else n_pass++;
      end
    end
    tick = 1'b0;
    cycle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_button = 1'b1;
    tick         = 1'b0;
    btn          = 7'h00;
    place_ack    = 1'b0;
    place_nack   = 1'b0;
    game_over    = 1'b0;
    test_reset();
    test_cursor();
    test_ack();
    test_nack();
    test_timeout();
    test_arbitration();
    test_restart();
    test_game_over_restart();
    test_countdown();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences play between the blue and red players on the 3x3 board. Arbitrates the shared button set and owns the cursor and turn flag.
- Runs a per-turn countdown for the seven-segment digit.
- Issues place requests to the board-state block via a req/ack/nack handshake, and generates the board-clear pulse.
- Sits between the raw button inputs and the board state/LED output path; the 8 Hz divider drives it through a one-cycle `tick` enable.

Parameters:
- TICKS_PER_SEC, 8: tick pulses per countdown second.
- TURN_SECONDS, 9: countdown reload value (1..9, single BCD digit).
- ACK_TIMEOUT, 15: clk cycles to wait for ack/nack before abandoning a request.

Ports:
- clk  in  1  system clock.
- reset_button  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle enable at 8 Hz, synchronous to clk.
- btn  in  7  raw button levels {blue_reset, red_reset, decision, up, down, left, right}.
- place_ack  in  1  board accepted the placement.
- place_nack  in  1  board rejected the placement (cell occupied).
- game_over  in  1  level from board: a win or a full board.
- cursor  out  4  selected cell 0..8 (row*3+col).
- turn  out  1  0 = blue, 1 = red.
- place_req  out  1  placement request, held until answered.
- place_cell  out  4  cell index for the request.
- place_player  out  1  player for the request.
- board_clear  out  1  one-cycle clear pulse to the board.
- sec_left  out  4  BCD seconds remaining.
- ack_err  out  1  one-cycle pulse on handshake timeout.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - reset_button is sampled synchronously.
- Reset values:
  - cursor=4, turn=0, place_req=0, place_cell=0, place_player=0.
  - board_clear=0, sec_left=TURN_SECONDS, ack_err=0.
  - FSM=PLAY, blue_want=0, red_want=0, tick_cnt=0.
  - Button history register = 7'h7F, so buttons held through reset do not fire.
- Edge detect: press = btn & ~btn_q. btn_q is updated every cycle.
- Arbitration: at most one press is honoured per cycle. Priority is blue_reset > red_reset > decision > up > down > left > right. Lower-priority presses in the same cycle are dropped, not queued.
- Cursor movement, honoured only in PLAY with game_over=0:
  - up: row-1, with row 0 wrapping to 2.
  - down: row+1, with row 2 wrapping to 0.
  - left: col-1, with col 0 wrapping to 2.
  - right: col+1, with col 2 wrapping to 0.
  - The cursor persists across turn changes.
- FSM states: PLAY, REQ, CLEAR.
  - PLAY to REQ: a decision press with game_over=0. place_cell<=cursor, place_player<=turn, place_req<=1, wait counter=0.
  - REQ, ack only: place_req<=0, turn toggles, sec_left reloads, tick_cnt=0, go to PLAY.
  - REQ, nack (including ack and nack in the same cycle): place_req<=0, turn unchanged, timer resumes, go to PLAY.
  - REQ, neither for ACK_TIMEOUT cycles: place_req<=0, ack_err pulses for one cycle, turn unchanged, go to PLAY.
  - REQ holds place_cell and place_player stable. Navigation and decision presses are ignored in REQ.
  - CLEAR: one cycle with board_clear=1. Then turn=0, cursor=4, sec_left reloads, wants clear, go to PLAY.
- Restart:
  - A blue_reset press sets blue_want; a red_reset press sets red_want. Both are honoured in any state.
  - When both are set, the FSM enters CLEAR next cycle. If in REQ, place_req is dropped at the same time.
  - If game_over=1, a single want from either player suffices.
- Countdown:
  - Advances only in PLAY with game_over=0 and tick=1. tick_cnt counts 0..TICKS_PER_SEC-1.
  - On wrap: if sec_left>0, decrement.
  - If sec_left==0 at wrap, forfeit: turn toggles and sec_left reloads.
  - The timer is frozen in REQ and CLEAR.
- Precedence in one cycle: reset_button > CLEAR entry > ack/nack/timeout > forfeit > honoured press.
  - A press in the same cycle as a forfeit is applied against the new turn.

Optional Feature:
- TURN_TIMER_EN defined: the countdown and forfeit operate as described above.
- TURN_TIMER_EN undefined:
  - No tick_cnt or forfeit logic is built, and tick is ignored.
  - sec_left is tied to 4'd0; turns change only on place_ack.

Test Plan:
- Reset, then right, right, down -> cursor 4->5->3->6; turn=0.
- Decision at cursor 6, ack 3 cycles later -> place_req high exactly 3 cycles with place_cell=6 and place_player=0; turn=1 after ack; sec_left=9.
- Decision, then nack together with ack -> treated as nack; turn unchanged; place_req drops next edge.
- Decision with no response -> place_req high 15 cycles; ack_err one-cycle pulse; back in PLAY.
- 80 ticks with no input (TURN_TIMER_EN) -> sec_left 9..0, forfeit on the 80th tick: turn=1, sec_left=9.
- blue_reset, then red_reset 20 cycles later -> board_clear one cycle; turn=0, cursor=4. With game_over=1, blue_reset alone -> board_clear.
